// File: rtl/id_ex_operand_stage_pkg.sv
// Shared constants, ALU op encodings and the ID/EX bundle.
// The bubble value is the all-zero bundle.
package id_ex_operand_stage_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int OP_W   = 3;

    typedef enum logic [OP_W-1:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLT = 3'd5,
        ALU_SLL = 3'd6,
        ALU_SRL = 3'd7
    } alu_op_e;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
        logic              use_imm;
        alu_op_e           alu_op;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              mem_to_reg;
    } id_ex_t;

    localparam id_ex_t BUBBLE = '0;

    // r0 is hardwired, so a write aimed at it never matches a source
    function automatic logic wr_hit(
        input logic              we,
        input logic [REG_AW-1:0] wrd,
        input logic [REG_AW-1:0] src
    );
        return we && (wrd != '0) && (wrd == src);
    endfunction

endpackage

// File: rtl/id_ex_operand_stage_fwd_mux.sv
// Operand forwarding select for one source register.
// EX/MEM has priority over MEM/WB; r0 always uses latched data.
module fwd_mux
    import id_ex_operand_stage_pkg::*;
(
    input  logic [REG_AW-1:0] i_idx,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_exmem_we,
    input  logic [REG_AW-1:0] i_exmem_rd,
    input  logic [DATA_W-1:0] i_exmem_val,
    input  logic              i_memwb_we,
    input  logic [REG_AW-1:0] i_memwb_rd,
    input  logic [DATA_W-1:0] i_memwb_val,
    output logic [DATA_W-1:0] o_val
);

    logic w_hit_exmem;
    logic w_hit_memwb;

    assign w_hit_exmem = wr_hit(i_exmem_we, i_exmem_rd, i_idx);
    assign w_hit_memwb = wr_hit(i_memwb_we, i_memwb_rd, i_idx);

    always_comb begin
        o_val = i_data;
        if (w_hit_exmem) begin
            o_val = i_exmem_val;
        end else if (w_hit_memwb) begin
            o_val = i_memwb_val;
        end
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with ALU operand forwarding,
// load-use hazard detection, stall write-snoop and flush.
module id_ex_operand_stage
    import id_ex_operand_stage_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_id_valid,
    input  logic [REG_AW-1:0] i_id_rs,
    input  logic [REG_AW-1:0] i_id_rt,
    input  logic [REG_AW-1:0] i_id_rd,
    input  logic [DATA_W-1:0] i_id_rs_data,
    input  logic [DATA_W-1:0] i_id_rt_data,
    input  logic [DATA_W-1:0] i_id_imm,
    input  logic              i_id_use_imm,
    input  logic [OP_W-1:0]   i_id_alu_op,
    input  logic              i_id_reg_write,
    input  logic              i_id_mem_read,
    input  logic              i_id_mem_write,
    input  logic              i_id_mem_to_reg,
    input  logic              i_stall,
    input  logic              i_flush,
    input  logic              i_exmem_reg_write,
    input  logic              i_memwb_reg_write,
    input  logic [REG_AW-1:0] i_exmem_rd,
    input  logic [REG_AW-1:0] i_memwb_rd,
    input  logic [DATA_W-1:0] i_exmem_result,
    input  logic [DATA_W-1:0] i_memwb_data,
    output logic [DATA_W-1:0] o_a,
    output logic [DATA_W-1:0] o_b,
    output logic [OP_W-1:0]   o_op,
    output logic [DATA_W-1:0] o_store_data,
    output logic              o_ex_valid,
    output logic [REG_AW-1:0] o_ex_rd,
    output logic              o_ex_reg_write,
    output logic              o_ex_mem_read,
    output logic              o_ex_mem_write,
    output logic              o_ex_mem_to_reg,
    output logic              o_load_use_stall
);

    id_ex_t            r_q;
    id_ex_t            w_load;
    logic              w_snoop_rs;
    logic              w_snoop_rt;
    logic [DATA_W-1:0] w_fwd_rs;
    logic [DATA_W-1:0] w_fwd_rt;
    logic              w_rt_used;

    always_comb begin
        w_load            = BUBBLE;
        w_load.valid      = 1'b1;
        w_load.rs         = i_id_rs;
        w_load.rt         = i_id_rt;
        w_load.rd         = i_id_rd;
        w_load.rs_data    = i_id_rs_data;
        w_load.rt_data    = i_id_rt_data;
        w_load.imm        = i_id_imm;
        w_load.use_imm    = i_id_use_imm;
        w_load.alu_op     = alu_op_e'(i_id_alu_op);
        w_load.reg_write  = i_id_reg_write;
        w_load.mem_read   = i_id_mem_read;
        w_load.mem_write  = i_id_mem_write;
        w_load.mem_to_reg = i_id_mem_to_reg;
    end

    assign w_snoop_rs = wr_hit(i_memwb_reg_write, i_memwb_rd, r_q.rs);
    assign w_snoop_rt = wr_hit(i_memwb_reg_write, i_memwb_rd, r_q.rt);

    // An invalid decode slot is latched as a bubble so it presents all zeros
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q <= BUBBLE;
        end else if (i_flush) begin
            r_q <= BUBBLE;
        end else if (i_stall) begin
            if (w_snoop_rs) begin
                r_q.rs_data <= i_memwb_data;
            end
            if (w_snoop_rt) begin
                r_q.rt_data <= i_memwb_data;
            end
        end else begin
            r_q <= i_id_valid ? w_load : BUBBLE;
        end
    end

    fwd_mux u_fwd_rs (
        .i_idx       (r_q.rs),
        .i_data      (r_q.rs_data),
        .i_exmem_we  (i_exmem_reg_write),
        .i_exmem_rd  (i_exmem_rd),
        .i_exmem_val (i_exmem_result),
        .i_memwb_we  (i_memwb_reg_write),
        .i_memwb_rd  (i_memwb_rd),
        .i_memwb_val (i_memwb_data),
        .o_val       (w_fwd_rs)
    );

    fwd_mux u_fwd_rt (
        .i_idx       (r_q.rt),
        .i_data      (r_q.rt_data),
        .i_exmem_we  (i_exmem_reg_write),
        .i_exmem_rd  (i_exmem_rd),
        .i_exmem_val (i_exmem_result),
        .i_memwb_we  (i_memwb_reg_write),
        .i_memwb_rd  (i_memwb_rd),
        .i_memwb_val (i_memwb_data),
        .o_val       (w_fwd_rt)
    );

    assign o_a          = w_fwd_rs;
    assign o_b          = r_q.use_imm ? r_q.imm : w_fwd_rt;
    assign o_store_data = w_fwd_rt;
    assign o_op         = r_q.alu_op;

    assign o_ex_valid      = r_q.valid;
    assign o_ex_rd         = r_q.rd;
    assign o_ex_reg_write  = r_q.reg_write;
    assign o_ex_mem_read   = r_q.mem_read;
    assign o_ex_mem_write  = r_q.mem_write;
    assign o_ex_mem_to_reg = r_q.mem_to_reg;

    // Stores need rt even when B takes the immediate
    assign w_rt_used = !i_id_use_imm || i_id_mem_write;

    assign o_load_use_stall = r_q.valid && r_q.mem_read
        && (r_q.rd != '0) && i_id_valid
        && ((r_q.rd == i_id_rs)
            || ((r_q.rd == i_id_rt) && w_rt_used));

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Bench for id_ex_operand_stage: directed vector table
// plus randomized traffic against a behavioural model.
module tb_id_ex_operand_stage;

    typedef struct packed {
        logic        rst;
        logic        valid;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] rsd;
        logic [31:0] rtd;
        logic [31:0] imm;
        logic        ui;
        logic [2:0]  op;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        mtr;
        logic        stall;
        logic        flush;
        logic        xw;
        logic [4:0]  xrd;
        logic [31:0] xres;
        logic        ww;
        logic [4:0]  wrd;
        logic [31:0] wdat;
        logic [31:0] e_a;
        logic [31:0] e_b;
        logic [31:0] e_sd;
        logic [2:0]  e_op;
        logic        e_v;
        logic        e_lus;
    } vec_t;

    logic  clk = 1'b0;
    vec_t  cur = '0;
    int    n_tests = 0;
    int    n_fail = 0;

    logic [31:0] o_a, o_b, o_store_data;
    logic [2:0]  o_op;
    logic [4:0]  o_ex_rd;
    logic        o_ex_valid, o_ex_reg_write, o_ex_mem_read;
    logic        o_ex_mem_write, o_ex_mem_to_reg, o_load_use_stall;

    always #5 clk = ~clk;

    id_ex_operand_stage dut (
        .i_clk             (clk),
        .i_rst             (cur.rst),
        .i_id_valid        (cur.valid),
        .i_id_rs           (cur.rs),
        .i_id_rt           (cur.rt),
        .i_id_rd           (cur.rd),
        .i_id_rs_data      (cur.rsd),
        .i_id_rt_data      (cur.rtd),
        .i_id_imm          (cur.imm),
        .i_id_use_imm      (cur.ui),
        .i_id_alu_op       (cur.op),
        .i_id_reg_write    (cur.rw),
        .i_id_mem_read     (cur.mr),
        .i_id_mem_write    (cur.mw),
        .i_id_mem_to_reg   (cur.mtr),
        .i_stall           (cur.stall),
        .i_flush           (cur.flush),
        .i_exmem_reg_write (cur.xw),
        .i_memwb_reg_write (cur.ww),
        .i_exmem_rd        (cur.xrd),
        .i_memwb_rd        (cur.wrd),
        .i_exmem_result    (cur.xres),
        .i_memwb_data      (cur.wdat),
        .o_a               (o_a),
        .o_b               (o_b),
        .o_op              (o_op),
        .o_store_data      (o_store_data),
        .o_ex_valid        (o_ex_valid),
        .o_ex_rd           (o_ex_rd),
        .o_ex_reg_write    (o_ex_reg_write),
        .o_ex_mem_read     (o_ex_mem_read),
        .o_ex_mem_write    (o_ex_mem_write),
        .o_ex_mem_to_reg   (o_ex_mem_to_reg),
        .o_load_use_stall  (o_load_use_stall)
    );

    // Behavioural model: the instruction currently in EX (or none)
    bit          m_v;
    int unsigned m_rs, m_rt, m_rd, m_op;
    logic [31:0] m_rsd, m_rtd, m_imm;
    bit          m_ui, m_rw, m_mr, m_mw, m_mtr;

    task automatic model_clear();
        m_v = 0; m_rs = 0; m_rt = 0; m_rd = 0; m_op = 0;
        m_rsd = 0; m_rtd = 0; m_imm = 0;
        m_ui = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_mtr = 0;
    endtask

    function automatic logic [31:0] fwd(input vec_t v,
                                        input int unsigned s,
                                        input logic [31:0] d);
        if (s != 0 && v.xw && v.xrd == s) return v.xres;
        if (s != 0 && v.ww && v.wrd == s) return v.wdat;
        return d;
    endfunction

    task automatic model_clock(input vec_t v);
        if (v.rst || v.flush) begin
            model_clear();
        end else if (v.stall) begin
            if (m_rs != 0 && v.ww && v.wrd == m_rs) m_rsd = v.wdat;
            if (m_rt != 0 && v.ww && v.wrd == m_rt) m_rtd = v.wdat;
        end else if (!v.valid) begin
            model_clear();
        end else begin
            m_v = 1; m_rs = v.rs; m_rt = v.rt; m_rd = v.rd;
            m_rsd = v.rsd; m_rtd = v.rtd; m_imm = v.imm;
            m_ui = v.ui; m_op = v.op; m_rw = v.rw;
            m_mr = v.mr; m_mw = v.mw; m_mtr = v.mtr;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     nm, act, act, exp, exp);
        end
    endtask

    task automatic model_check(input string tag, input vec_t v);
        logic [31:0] ea, eb, esd;
        bit          lus;
        ea  = fwd(v, m_rs, m_rsd);
        esd = fwd(v, m_rt, m_rtd);
        eb  = m_ui ? m_imm : esd;
        lus = m_v && m_mr && m_rd != 0 && v.valid &&
              (m_rd == v.rs || (m_rd == v.rt && (!v.ui || v.mw)));
        chk({tag, ".A"}, o_a, ea);
        chk({tag, ".B"}, o_b, eb);
        chk({tag, ".sd"}, o_store_data, esd);
        chk({tag, ".op"}, 32'(o_op), m_op);
        chk({tag, ".ctl"},
            {25'd0, o_ex_valid, o_ex_rd, o_ex_reg_write},
            {25'd0, 1'(m_v), 5'(m_rd), 1'(m_rw)});
        chk({tag, ".mem"},
            {29'd0, o_ex_mem_read, o_ex_mem_write, o_ex_mem_to_reg},
            {29'd0, 1'(m_mr), 1'(m_mw), 1'(m_mtr)});
        chk({tag, ".lus"}, 32'(o_load_use_stall), 32'(lus));
    endtask

    task automatic tab_check(input string tag, input vec_t v);
        chk({tag, ".tA"}, o_a, v.e_a);
        chk({tag, ".tB"}, o_b, v.e_b);
        chk({tag, ".tsd"}, o_store_data, v.e_sd);
        chk({tag, ".top"}, 32'(o_op), 32'(v.e_op));
        chk({tag, ".tv"}, 32'(o_ex_valid), 32'(v.e_v));
        chk({tag, ".tlus"}, 32'(o_load_use_stall), 32'(v.e_lus));
    endtask

    // mode 0: drive only, 1: model check, 2: model + table check
    task automatic step(input vec_t v, input int mode, input string tag);
        cur = v;
        #1;
        if (mode >= 1) model_check(tag, v);
        if (mode == 2) tab_check(tag, v);
        @(posedge clk);
        model_clock(v);
        #1;
    endtask

    vec_t tab[$];
    vec_t v;

    initial begin
        model_clear();
        @(posedge clk);
        #1;

        // Reset with a load pattern driven at the decode inputs
        v = '0;
        v.rst = 1; v.valid = 1; v.mr = 1; v.rw = 1;
        v.rs = 5; v.rt = 5; v.rd = 5; v.rsd = 123; v.rtd = 456;
        step(v, 0, "rst0");
        step(v, 0, "rst1");
        cur = v;
        #1;
        chk("rst.A", o_a, 0);
        chk("rst.B", o_b, 0);
        chk("rst.sd", o_store_data, 0);
        chk("rst.op", 32'(o_op), 0);
        chk("rst.valid", 32'(o_ex_valid), 0);
        chk("rst.rd", 32'(o_ex_rd), 0);
        chk("rst.ctl", {28'd0, o_ex_reg_write, o_ex_mem_read,
                        o_ex_mem_write, o_ex_mem_to_reg}, 0);
        chk("rst.lus", 32'(o_load_use_stall), 0);
        model_check("rst", v);
        @(posedge clk);
        model_clock(v);
        #1;

        // Directed vector table (expectations for the state before each edge)
        v = '0;
        v.valid = 1; v.rs = 3; v.rt = 4; v.rd = 6;
        v.rsd = 905; v.rtd = 267; v.rw = 1;
        tab.push_back(v);
        v.xw = 1; v.xrd = 3; v.xres = 17;
        v.ww = 1; v.wrd = 3; v.wdat = 99;
        v.e_a = 17; v.e_b = 267; v.e_sd = 267; v.e_v = 1;
        tab.push_back(v);
        v.xw = 0; v.e_a = 99;
        tab.push_back(v);
        v.xw = 1; v.xrd = 0; v.wrd = 0; v.e_a = 905;
        v.ui = 1; v.imm = 11738; v.op = 3'd2;
        tab.push_back(v);
        v.xw = 1; v.xrd = 4; v.xres = 77738293; v.ww = 0;
        v.e_a = 905; v.e_b = 11738; v.e_sd = 77738293; v.e_op = 2;
        v.rs = 1; v.rt = 5; v.rd = 5; v.rsd = 1000; v.rtd = 0;
        v.imm = 8; v.ui = 1; v.op = 0; v.mr = 1; v.mtr = 1;
        tab.push_back(v);
        v.xw = 0; v.flush = 1;
        v.rs = 5; v.rt = 2; v.rd = 7; v.rsd = 32'h123; v.rtd = 50;
        v.imm = 0; v.ui = 0; v.mr = 0; v.mtr = 0;
        v.e_a = 1000; v.e_b = 8; v.e_sd = 0; v.e_op = 0; v.e_lus = 1;
        tab.push_back(v);
        v.flush = 0;
        v.e_a = 0; v.e_b = 0; v.e_sd = 0; v.e_v = 0; v.e_lus = 0;
        tab.push_back(v);
        v.stall = 1; v.ww = 1; v.wrd = 5; v.wdat = 289;
        v.e_a = 289; v.e_b = 50; v.e_sd = 50; v.e_v = 1;
        tab.push_back(v);
        v.stall = 0; v.ww = 0; v.wrd = 0; v.wdat = 0;
        v.rs = 8; v.rt = 9; v.rd = 10; v.rsd = 11; v.rtd = 22; v.op = 3;
        tab.push_back(v);
        v.stall = 1; v.flush = 1;
        v.e_a = 11; v.e_b = 22; v.e_sd = 22; v.e_op = 3;
        tab.push_back(v);
        v.stall = 0; v.flush = 0;
        v.rs = 10; v.rt = 11; v.rd = 12; v.rsd = 44; v.rtd = 55; v.op = 5;
        v.e_a = 0; v.e_b = 0; v.e_sd = 0; v.e_op = 0; v.e_v = 0;
        tab.push_back(v);
        v.stall = 1; v.rs = 13; v.rsd = 66; v.op = 1;
        v.e_a = 44; v.e_b = 55; v.e_sd = 55; v.e_op = 5; v.e_v = 1;
        tab.push_back(v);
        v.rs = 14; v.rsd = 77;
        tab.push_back(v);
        v.rt = 15; v.rtd = 88;
        tab.push_back(v);
        v.stall = 0;
        tab.push_back(v);

        foreach (tab[i]) step(tab[i], 2, $sformatf("tab%0d", i));

        // Randomized traffic, small register space to provoke hazards
        for (int n = 0; n < 400; n++) begin
            v = '0;
            v.rst   = ($urandom_range(0, 49) == 0);
            v.valid = ($urandom_range(0, 9) != 0);
            v.rs    = 5'($urandom_range(0, 7));
            v.rt    = 5'($urandom_range(0, 7));
            v.rd    = 5'($urandom_range(0, 7));
            v.rsd   = $urandom;
            v.rtd   = $urandom;
            v.imm   = $urandom;
            v.ui    = 1'($urandom_range(0, 1));
            v.op    = 3'($urandom_range(0, 7));
            v.rw    = 1'($urandom_range(0, 1));
            v.mr    = ($urandom_range(0, 2) == 0);
            v.mw    = ($urandom_range(0, 3) == 0);
            v.mtr   = 1'($urandom_range(0, 1));
            v.stall = ($urandom_range(0, 4) == 0);
            v.flush = ($urandom_range(0, 9) == 0);
            v.xw    = 1'($urandom_range(0, 1));
            v.xrd   = 5'($urandom_range(0, 7));
            v.xres  = $urandom;
            v.ww    = 1'($urandom_range(0, 1));
            v.wrd   = 5'($urandom_range(0, 7));
            v.wdat  = $urandom;
            step(v, 1, $sformatf("rnd%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
